io_bus_master: RTL and testbench

Synchronous master for the Sextium III 16-bit asynchronous I/O bus. Takes single read/write requests from the CPU core over a valid/ready interface and runs a four-phase strobe/acknowledge handshake (io_read / io_write / ioack) on the shared tri-state data bus. Returns read data or write completion through a one-cycle response, with a cycle-count timeout for absent devices. Sits between the core's I/O instruction logic and the I/O devices.

---
 rtl/io_bus_master_pkg.sv | 23 ++
 rtl/io_bus_master_sync_2ff.sv | 24 ++
 rtl/io_bus_master.sv | 180 ++++++++++++++++++
 tb/tb_io_bus_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_master_pkg.sv
// Shared definitions for the Sextium III I/O bus master: state encodings
// and default widths.
package io_bus_master_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_TIMEOUT    = 255;
   localparam int WAIT_CNT_WIDTH     = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_REQ   = 3'd1,
      RD_REL   = 3'd2,
      WR_SETUP = 3'd3,
      WR_REQ   = 3'd4,
      WR_REL   = 3'd5
   } state_t;

   // States in which the block is waiting on the device and may time out.
   function automatic logic is_wait_state(input state_t s);
      return (s == RD_REQ) || (s == RD_REL) || (s == WR_REQ) || (s == WR_REL);
   endfunction

endpackage

// File: rtl/io_bus_master_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two back-to-back flops; only q is safe to use in the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/io_bus_master.sv
// Sextium III I/O bus master: one core request at a time, run as a
// four-phase strobe/ack handshake with a per-phase timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | req_ready high, waiting for a core request
// RD_REQ   | io_read high, waiting for ack_s rise; data captured on it
// RD_REL   | io_read low, waiting for ack_s to fall
// WR_SETUP | write data driven one cycle before io_write rises
// WR_REQ   | io_write high, waiting for ack_s rise
// WR_REL   | io_write low, data still driven, waiting for ack_s to fall
module io_bus_master
   import io_bus_master_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_timeout,
   output logic                  io_read,
   output logic                  io_write,
   input  logic                  ioack,
   inout  wire  [DATA_WIDTH-1:0] data
);

   // Abort is decided in the last allowed wait cycle, so a phase never
   // lasts more than TIMEOUT cycles; TO_MAX is the saturation ceiling.
   localparam logic [WAIT_CNT_WIDTH-1:0] TO_LAST = WAIT_CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [WAIT_CNT_WIDTH-1:0] TO_MAX  = WAIT_CNT_WIDTH'(TIMEOUT);

   state_t                    state, state_n;
   logic                      ack_s;
   logic                      data_oe, data_oe_n;
   logic                      io_read_n, io_write_n;
   logic                      req_ready_n, resp_valid_n, resp_timeout_n;
   logic [DATA_WIDTH-1:0]     rdata_n;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_n;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt, wait_cnt_n;
   logic                      timed_out;

   sync_2ff #(.WIDTH(1)) u_ack_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ioack),
      .q     (ack_s)
   );

   assign data = data_oe ? wdata_q : {DATA_WIDTH{1'bz}};

   // State and every output are registered; reset drops strobes at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_timeout <= 1'b0;
         io_read      <= 1'b0;
         io_write     <= 1'b0;
         data_oe      <= 1'b0;
         wdata_q      <= '0;
         wait_cnt     <= '0;
      end else begin
         state        <= state_n;
         req_ready    <= req_ready_n;
         resp_valid   <= resp_valid_n;
         resp_rdata   <= rdata_n;
         resp_timeout <= resp_timeout_n;
         io_read      <= io_read_n;
         io_write     <= io_write_n;
         data_oe      <= data_oe_n;
         wdata_q      <= wdata_n;
         wait_cnt     <= wait_cnt_n;
      end
   end

   // Next-state, next-output and wait-counter logic.
   always_comb begin
      state_n        = state;
      io_read_n      = io_read;
      io_write_n     = io_write;
      data_oe_n      = data_oe;
      resp_valid_n   = 1'b0;
      resp_timeout_n = 1'b0;
      rdata_n        = resp_rdata;
      wdata_n        = wdata_q;
      timed_out      = is_wait_state(state) && (wait_cnt >= TO_LAST);

      case (state)
         IDLE: begin
            // req_ready gates acceptance so nothing is taken in the
            // first cycle after reset release.
            if (req_ready && req_valid) begin
               wdata_n = req_wdata;
               if (req_write) begin
                  state_n   = WR_SETUP;
                  data_oe_n = 1'b1;
               end else begin
                  state_n   = RD_REQ;
                  io_read_n = 1'b1;
               end
            end
         end
         RD_REQ: begin
            if (ack_s) begin
               rdata_n   = data;
               io_read_n = 1'b0;
               state_n   = RD_REL;
            end else if (timed_out) begin
               state_n = IDLE;
            end
         end
         RD_REL: begin
            if (!ack_s) begin
               state_n      = IDLE;
               resp_valid_n = 1'b1;
            end else if (timed_out) begin
               state_n = IDLE;
            end
         end
         WR_SETUP: begin
            io_write_n = 1'b1;
            state_n    = WR_REQ;
         end
         WR_REQ: begin
            if (ack_s) begin
               io_write_n = 1'b0;
               state_n    = WR_REL;
            end else if (timed_out) begin
               state_n = IDLE;
            end
         end
         WR_REL: begin
            if (!ack_s) begin
               data_oe_n    = 1'b0;
               rdata_n      = '0;
               state_n      = IDLE;
               resp_valid_n = 1'b1;
            end else if (timed_out) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n    = IDLE;
            io_read_n  = 1'b0;
            io_write_n = 1'b0;
            data_oe_n  = 1'b0;
         end
      endcase

      // An ack seen in the final allowed cycle still completes normally;
      // only a wait that made no progress is aborted.
      if (timed_out && (state_n == IDLE) && !resp_valid_n) begin
         io_read_n      = 1'b0;
         io_write_n     = 1'b0;
         data_oe_n      = 1'b0;
         rdata_n        = '0;
         resp_valid_n   = 1'b1;
         resp_timeout_n = 1'b1;
      end

      req_ready_n = (state_n == IDLE);

      if (state_n != state) begin
         wait_cnt_n = '0;
      end else if (is_wait_state(state) && (wait_cnt < TO_MAX)) begin
         wait_cnt_n = WAIT_CNT_WIDTH'(wait_cnt + 1'b1);
      end else begin
         wait_cnt_n = wait_cnt;
      end
   end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master with a behavioural I/O device model.
module tb_io_bus_master;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_timeout;
   logic        io_read;
   logic        io_write;
   logic        ioack;
   wire  [15:0] data;

   int n_vec = 0;
   int n_err = 0;
   int c     = 0;

   // Device model: input/output buffers, programmable ack delay.
   logic [15:0] in_mem  [0:7];
   logic [15:0] out_mem [0:7];
   logic [2:0]  rd_idx  = '0;
   logic [2:0]  wr_idx  = '0;
   logic        io_read_q = 1'b0;
   logic        wr_seen   = 1'b0;
   logic        ack_en    = 1'b1;
   int          dev_delay = 0;
   int          hi_cnt    = 0;
   logic [15:0] dev_rdata;

   io_bus_master #(.DATA_WIDTH(16), .TIMEOUT(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_timeout (resp_timeout),
      .io_read      (io_read),
      .io_write     (io_write),
      .ioack        (ioack),
      .data         (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dev_rdata = in_mem[rd_idx];
   assign data      = io_read ? dev_rdata : 16'hzzzz;
   assign ioack     = ack_en && (io_read || io_write) && (hi_cnt >= dev_delay);

   always @(posedge clk) begin
      hi_cnt    <= (io_read || io_write) ? hi_cnt + 1 : 0;
      io_read_q <= io_read;
      if (io_read_q && !io_read) rd_idx <= rd_idx + 3'd1;
      if (io_write && ioack && !wr_seen) begin
         out_mem[wr_idx] <= data;
         wr_idx          <= wr_idx + 3'd1;
         wr_seen         <= 1'b1;
      end else if (!io_write) begin
         wr_seen <= 1'b0;
      end
   end

   always @(negedge clk) begin
      assert (!(io_read && io_write)) else begin
         n_err++;
         $error("FAIL strobe_excl: io_read=%0b io_write=%0b required not both 1", io_read, io_write);
      end
      assert (!(io_read && dut.data_oe)) else begin
         n_err++;
         $error("FAIL oe_vs_read: io_read=%0b data_oe=%0b required not both 1", io_read, dut.data_oe);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic goto(input int n);
      while (c < n) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic start(input logic wr, input logic [15:0] wd);
      req_valid = 1'b1;
      req_write = wr;
      req_wdata = wd;
      c = 0;
   endtask

   initial begin
      in_mem[0] = 16'h1234; in_mem[1] = 16'h1111; in_mem[2] = 16'hCAFE;
      in_mem[3] = 16'h0F0F; in_mem[4] = 16'hA5C3; in_mem[5] = 16'h7E57;
      in_mem[6] = 16'h0000; in_mem[7] = 16'h0000;
      for (int i = 0; i < 8; i++) out_mem[i] = 16'h0000;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;

      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_strobes", {io_read, io_write, dut.data_oe}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);

      // zero-delay read
      start(0, 16'h0);
      goto(1); req_valid = 1'b0;
      chk("rd_ioread_c1", io_read, 1);
      goto(3); chk("rd_ioread_c3", io_read, 1);
      goto(4); chk("rd_ioread_c4", io_read, 0);
      goto(6); chk("rd_resp_c6", resp_valid, 0);
      goto(7);
      chk("rd_resp_c7", resp_valid, 1);
      chk("rd_rdata", resp_rdata, 16'h1234);
      chk("rd_timeout", resp_timeout, 0);
      chk("rd_ready_c7", req_ready, 1);
      chk("rd_dev_idx", rd_idx, 1);

      // device never acks: timeout after 8 wait cycles, rdata cleared
      ack_en = 1'b0;
      start(0, 16'h0);
      goto(1); req_valid = 1'b0;
      chk("to_ioread_c1", io_read, 1);
      goto(8);
      chk("to_ioread_c8", io_read, 1);
      chk("to_resp_c8", resp_valid, 0);
      goto(9);
      chk("to_ioread_c9", io_read, 0);
      chk("to_resp_c9", resp_valid, 1);
      chk("to_flag", resp_timeout, 1);
      chk("to_rdata", resp_rdata, 0);
      chk("to_ready", req_ready, 1);
      ack_en = 1'b1;

      // zero-delay write
      start(1, 16'hBEEF);
      goto(1); req_valid = 1'b0;
      chk("wr_oe_c1", dut.data_oe, 1);
      chk("wr_iowrite_c1", io_write, 0);
      chk("wr_bus_c1", data, 16'hBEEF);
      goto(2); chk("wr_iowrite_c2", io_write, 1);
      goto(4); chk("wr_iowrite_c4", io_write, 1);
      goto(5); chk("wr_iowrite_c5", {io_write, dut.data_oe}, 2'b01);
      goto(7); chk("wr_c7", {dut.data_oe, resp_valid}, 2'b10);
      goto(8);
      chk("wr_c8", {dut.data_oe, resp_valid, resp_timeout}, 3'b010);
      chk("wr_rdata", resp_rdata, 0);
      chk("wr_dev_store", out_mem[0], 16'hBEEF);
      chk("wr_dev_idx", wr_idx, 1);

      // ack delayed 5 cycles: latency 12, ack lands in the last allowed cycle
      dev_delay = 5;
      start(0, 16'h0);
      goto(1); req_valid = 1'b0;
      goto(8); chk("dly_ioread_c8", io_read, 1);
      goto(9); chk("dly_ioread_c9", io_read, 0);
      goto(11); chk("dly_resp_c11", resp_valid, 0);
      goto(12);
      chk("dly_resp_c12", {resp_valid, resp_timeout}, 2'b10);
      chk("dly_rdata", resp_rdata, 16'hCAFE);

      // back-to-back read, write, read with req_valid held
      dev_delay = 0;
      start(0, 16'h0);
      goto(1); req_write = 1'b1; req_wdata = 16'h5A5A;
      goto(7);
      chk("b2b_r1_resp", {resp_valid, req_ready}, 2'b11);
      chk("b2b_r1_rdata", resp_rdata, 16'h0F0F);
      goto(8);
      chk("b2b_w_accept", dut.data_oe, 1);
      req_write = 1'b0;
      goto(15);
      chk("b2b_w_resp", {resp_valid, req_ready}, 2'b11);
      chk("b2b_w_rdata", resp_rdata, 0);
      goto(16); chk("b2b_r2_accept", io_read, 1);
      goto(22);
      chk("b2b_r2_resp", {resp_valid, resp_timeout}, 2'b10);
      chk("b2b_r2_rdata", resp_rdata, 16'hA5C3);
      req_valid = 1'b0;
      chk("b2b_w_store", out_mem[1], 16'h5A5A);

      // reset while io_write is high
      dev_delay = 5;
      start(1, 16'h1357);
      goto(1); req_valid = 1'b0;
      goto(3); chk("rst_mid_iowrite", io_write, 1);
      reset = 1'b1;
      #1;
      chk("rst_mid_drop", {io_write, dut.data_oe, resp_valid}, 0);
      goto(4); reset = 1'b0;
      goto(5); chk("rst_mid_ready", req_ready, 1);
      dev_delay = 0;
      start(0, 16'h0);
      goto(1); req_valid = 1'b0;
      goto(7);
      chk("post_rst_resp", {resp_valid, resp_timeout}, 2'b10);
      chk("post_rst_rdata", resp_rdata, 16'h7E57);
      chk("post_rst_wr_idx", wr_idx, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
